// File: rtl/l1d_write_buffer.sv
// l1d_write_buffer
// Posted-write FIFO between the L1D miss/writeback port and the lower cache.
// Writes are acknowledged one cycle after acceptance and drained in order.
// A read first drains every older buffered write, then issues a single
// lower-cache read and returns the data to L1D.
// Optional feature macro: WB_FWD_EN -- a read that matches a buffered write
// is answered directly from the buffer (youngest match wins).
module l1d_write_buffer #(
    parameter int PADDR_BITS = 22,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  l1_valid_in,
    output logic                  l1_ready_out,
    input  logic [PADDR_BITS-1:0] l1_addr_in,
    input  logic [63:0]           l1_value_in,
    input  logic                  l1_we_in,
    output logic                  l1_write_complete_out,
    output logic                  l1_valid_out,
    input  logic                  l1_ready_in,
    output logic [PADDR_BITS-1:0] l1_addr_out,
    output logic [63:0]           l1_value_out,
    output logic                  lc_valid_out,
    input  logic                  lc_ready_in,
    output logic [PADDR_BITS-1:0] lc_addr_out,
    output logic [63:0]           lc_value_out,
    output logic                  lc_we_out,
    input  logic                  lc_valid_in,
    output logic                  lc_ready_out,
    input  logic [PADDR_BITS-1:0] lc_addr_in,
    input  logic [63:0]           lc_value_in
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        RD_REQ,
        RD_WAIT,
        RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [PADDR_BITS-1:0]   addr_mem_q [DEPTH];
    logic [63:0]             data_mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q, count_d, post_pop_cnt;
    logic [PADDR_BITS-1:0]   rd_addr_q, rd_addr_d;
    logic [63:0]             rd_data_q, rd_data_d;
    logic                    wc_pulse_q;
    logic                    drain_act, push, pop, l1_fire;

    // Read-data address from the lower cache carries no information here.
    logic unused_lc_addr;
    assign unused_lc_addr = ^lc_addr_in;

    // Handshake qualification and occupancy bookkeeping.
    // NOTE: every signal driven from always_comb gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        drain_act    = ((state_q == IDLE) || (state_q == DRAIN)) && (count_q != '0);
        pop          = drain_act && lc_ready_in;
        l1_ready_out = !rst_in && (state_q == IDLE) && (count_q < CNT_FULL);
        l1_fire      = l1_valid_in && l1_ready_out;
        push         = l1_fire && l1_we_in;
        post_pop_cnt = count_q - CNT_W'(pop);
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    end

`ifdef WB_FWD_EN
    logic             fwd_hit;
    logic [63:0]      fwd_data;
    logic [PTR_W-1:0] fwd_idx;

    // Scan live entries oldest to youngest so the youngest match wins;
    // the head is still live in the cycle it pops.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (addr_mem_q[fwd_idx] == l1_addr_in)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem_q[fwd_idx];
            end
        end
    end
`endif

    // Next-state logic and read-holding register updates.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        unique case (state_q)
            IDLE: begin
                if (l1_fire && !l1_we_in) begin
                    rd_addr_d = l1_addr_in;
`ifdef WB_FWD_EN
                    if (fwd_hit) begin
                        rd_data_d = fwd_data;
                        state_d   = RESP;
                    end else if (post_pop_cnt != '0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RD_REQ;
                    end
`else
                    if (post_pop_cnt != '0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RD_REQ;
                    end
`endif
                end
            end
            DRAIN: begin
                if (post_pop_cnt == '0) begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                if (lc_ready_in) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lc_valid_in) begin
                    rd_data_d = lc_value_in;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (l1_ready_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lower-cache request port: buffered writes take the port in IDLE/DRAIN,
    // the single outstanding read uses it in RD_REQ.
    always_comb begin
        lc_valid_out = 1'b0;
        lc_we_out    = 1'b0;
        lc_addr_out  = '0;
        lc_value_out = '0;
        if (drain_act) begin
            lc_valid_out = 1'b1;
            lc_we_out    = 1'b1;
            lc_addr_out  = addr_mem_q[rd_ptr_q];
            lc_value_out = data_mem_q[rd_ptr_q];
        end else if (state_q == RD_REQ) begin
            lc_valid_out = 1'b1;
            lc_addr_out  = rd_addr_q;
        end
    end

    assign lc_ready_out          = (state_q == RD_WAIT);
    assign l1_valid_out          = (state_q == RESP);
    assign l1_addr_out           = rd_addr_q;
    assign l1_value_out          = rd_data_q;
    assign l1_write_complete_out = wc_pulse_q;

    // Control state, pointers, occupancy and read-holding registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            wc_pulse_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            count_q    <= count_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
            wc_pulse_q <= push;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Entry storage written on push.
    // NOTE: the array is not reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk_in) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= l1_addr_in;
            data_mem_q[wr_ptr_q] <= l1_value_in;
        end
    end

endmodule

// File: tb/tb_l1d_write_buffer.sv
// Directed bench for l1d_write_buffer: a per-cycle vector table for reset,
// a posted write and a drain-then-read, plus hand-written multi-cycle
// sequences for ordering, back-pressure, reset mid-read and forwarding
// (forwarding sequence only when WB_FWD_EN is defined).
module tb_l1d_write_buffer;

    localparam int AW = 22;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          l1_valid_in, l1_we_in, l1_ready_in;
    logic [AW-1:0] l1_addr_in;
    logic [63:0]   l1_value_in;
    logic          lc_ready_in, lc_valid_in;
    logic [AW-1:0] lc_addr_in;
    logic [63:0]   lc_value_in;
    logic          l1_ready_out, l1_write_complete_out, l1_valid_out;
    logic [AW-1:0] l1_addr_out, lc_addr_out;
    logic [63:0]   l1_value_out, lc_value_out;
    logic          lc_valid_out, lc_we_out, lc_ready_out;

    int n_vec;
    int n_err;

    always #5 clk_in = ~clk_in;

    l1d_write_buffer dut (
        .clk_in                (clk_in),
        .rst_in                (rst_in),
        .l1_valid_in           (l1_valid_in),
        .l1_ready_out          (l1_ready_out),
        .l1_addr_in            (l1_addr_in),
        .l1_value_in           (l1_value_in),
        .l1_we_in              (l1_we_in),
        .l1_write_complete_out (l1_write_complete_out),
        .l1_valid_out          (l1_valid_out),
        .l1_ready_in           (l1_ready_in),
        .l1_addr_out           (l1_addr_out),
        .l1_value_out          (l1_value_out),
        .lc_valid_out          (lc_valid_out),
        .lc_ready_in           (lc_ready_in),
        .lc_addr_out           (lc_addr_out),
        .lc_value_out          (lc_value_out),
        .lc_we_out             (lc_we_out),
        .lc_valid_in           (lc_valid_in),
        .lc_ready_out          (lc_ready_out),
        .lc_addr_in            (lc_addr_in),
        .lc_value_in           (lc_value_in)
    );

    typedef struct packed {
        logic          rst, v, we;
        logic [AW-1:0] a;
        logic [63:0]   d;
        logic          l1r, lcr, lcv;
        logic [63:0]   lcd;
    } ins_t;

    typedef struct packed {
        logic          rdy, wc, lcv, lcwe;
        logic [AW-1:0] lca;
        logic [63:0]   lcd;
        logic          l1v;
        logic [AW-1:0] l1a;
        logic [63:0]   l1d;
        logic          lcro;
    } outs_t;

    typedef struct {
        ins_t  in;
        bit    chk;
        outs_t exp;
    } vec_t;

    vec_t tbl[16];

    function automatic ins_t mk_in(logic rst, logic v, logic we, logic [AW-1:0] a, logic [63:0] d,
                                   logic l1r, logic lcr, logic lcv, logic [63:0] lcd);
        ins_t x;
        x.rst = rst; x.v = v; x.we = we; x.a = a; x.d = d;
        x.l1r = l1r; x.lcr = lcr; x.lcv = lcv; x.lcd = lcd;
        return x;
    endfunction

    function automatic outs_t mk_out(logic rdy, logic wc, logic lcv, logic lcwe, logic [AW-1:0] lca,
                                     logic [63:0] lcd, logic l1v, logic [AW-1:0] l1a,
                                     logic [63:0] l1d, logic lcro);
        outs_t o;
        o.rdy = rdy; o.wc = wc; o.lcv = lcv; o.lcwe = lcwe; o.lca = lca; o.lcd = lcd;
        o.l1v = l1v; o.l1a = l1a; o.l1d = l1d; o.lcro = lcro;
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.rdy = l1_ready_out;  o.wc = l1_write_complete_out;
        o.lcv = lc_valid_out;  o.lcwe = lc_we_out;
        o.lca = lc_addr_out;   o.lcd = lc_value_out;
        o.l1v = l1_valid_out;  o.l1a = l1_addr_out;
        o.l1d = l1_value_out;  o.lcro = lc_ready_out;
        return o;
    endfunction

    task automatic apply(input ins_t x);
        rst_in      = x.rst;
        l1_valid_in = x.v;
        l1_we_in    = x.we;
        l1_addr_in  = x.a;
        l1_value_in = x.d;
        l1_ready_in = x.l1r;
        lc_ready_in = x.lcr;
        lc_valid_in = x.lcv;
        lc_value_in = x.lcd;
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Waits (bounded) until the read reaches RD_WAIT.
    task automatic wait_rd_wait(input string name);
        int n = 0;
        while (!lc_ready_out && n < 8) begin
            @(negedge clk_in);
            n++;
        end
        check(name, 256'(lc_ready_out), 256'(1'b1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        outs_t z;
        n_vec      = 0;
        n_err      = 0;
        lc_addr_in = 22'h3FFFFF;
        z = mk_out(1'b0, 1'b0, 1'b0, 1'b0, 22'h0, 64'h0, 1'b0, 22'h0, 64'h0, 1'b0);

        // Each row: inputs for one cycle; expected outputs are those seen
        // during that cycle (state left by the previous rows).
        tbl[0]  = '{mk_in(1, 0, 0, 22'h0, 64'h0, 0, 0, 0, 64'h0), 1'b0, z};
        tbl[1]  = '{mk_in(1, 0, 0, 22'h0, 64'h0, 0, 0, 0, 64'h0), 1'b1, z};
        tbl[2]  = '{mk_in(0, 0, 0, 22'h0, 64'h0, 0, 0, 0, 64'h0), 1'b1,
                    mk_out(1, 0, 0, 0, 22'h0, 64'h0, 0, 22'h0, 64'h0, 0)};
        tbl[3]  = '{mk_in(0, 1, 1, 22'h100, 64'hAAAA, 0, 1, 0, 64'h0), 1'b1,
                    mk_out(1, 0, 0, 0, 22'h0, 64'h0, 0, 22'h0, 64'h0, 0)};
        tbl[4]  = '{mk_in(0, 0, 0, 22'h0, 64'h0, 0, 1, 0, 64'h0), 1'b1,
                    mk_out(1, 1, 1, 1, 22'h100, 64'hAAAA, 0, 22'h0, 64'h0, 0)};
        tbl[5]  = '{mk_in(0, 0, 0, 22'h0, 64'h0, 0, 1, 0, 64'h0), 1'b1,
                    mk_out(1, 0, 0, 0, 22'h0, 64'h0, 0, 22'h0, 64'h0, 0)};
        tbl[6]  = '{mk_in(0, 1, 1, 22'h20, 64'h5555, 0, 0, 0, 64'h0), 1'b1,
                    mk_out(1, 0, 0, 0, 22'h0, 64'h0, 0, 22'h0, 64'h0, 0)};
        tbl[7]  = '{mk_in(0, 1, 0, 22'h40, 64'h0, 0, 0, 0, 64'h0), 1'b1,
                    mk_out(1, 1, 1, 1, 22'h20, 64'h5555, 0, 22'h0, 64'h0, 0)};
        tbl[8]  = '{mk_in(0, 0, 0, 22'h0, 64'h0, 0, 1, 0, 64'h0), 1'b1,
                    mk_out(0, 0, 1, 1, 22'h20, 64'h5555, 0, 22'h40, 64'h0, 0)};
        tbl[9]  = '{mk_in(0, 0, 0, 22'h0, 64'h0, 0, 0, 0, 64'h0), 1'b1,
                    mk_out(0, 0, 1, 0, 22'h40, 64'h0, 0, 22'h40, 64'h0, 0)};
        tbl[10] = '{mk_in(0, 0, 0, 22'h0, 64'h0, 0, 1, 0, 64'h0), 1'b1,
                    mk_out(0, 0, 1, 0, 22'h40, 64'h0, 0, 22'h40, 64'h0, 0)};
        tbl[11] = '{mk_in(0, 0, 0, 22'h0, 64'h0, 0, 0, 0, 64'h0), 1'b1,
                    mk_out(0, 0, 0, 0, 22'h0, 64'h0, 0, 22'h40, 64'h0, 1)};
        tbl[12] = '{mk_in(0, 0, 0, 22'h0, 64'h0, 0, 0, 1, 64'hBEEF), 1'b1,
                    mk_out(0, 0, 0, 0, 22'h0, 64'h0, 0, 22'h40, 64'h0, 1)};
        tbl[13] = '{mk_in(0, 0, 0, 22'h0, 64'h0, 0, 0, 0, 64'h0), 1'b1,
                    mk_out(0, 0, 0, 0, 22'h0, 64'h0, 1, 22'h40, 64'hBEEF, 0)};
        tbl[14] = '{mk_in(0, 0, 0, 22'h0, 64'h0, 1, 0, 0, 64'h0), 1'b1,
                    mk_out(0, 0, 0, 0, 22'h0, 64'h0, 1, 22'h40, 64'hBEEF, 0)};
        tbl[15] = '{mk_in(0, 0, 0, 22'h0, 64'h0, 0, 1, 0, 64'h0), 1'b1,
                    mk_out(1, 0, 0, 0, 22'h0, 64'h0, 0, 22'h40, 64'hBEEF, 0)};

        for (int k = 0; k < 16; k++) begin
            apply(tbl[k].in);
            #1;
            if (tbl[k].chk) begin
                check($sformatf("tbl_row%0d", k), 256'(sample()), 256'(tbl[k].exp));
            end
            @(negedge clk_in);
        end

        // Fill to full with the lower cache stalled, then drain in order.
        apply(mk_in(0, 0, 0, 22'h0, 64'h0, 0, 0, 0, 64'h0));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill_ready_%0d", i), 256'(l1_ready_out), 256'(1'b1));
            l1_valid_in = 1'b1;
            l1_we_in    = 1'b1;
            l1_addr_in  = AW'(32'h10 + i);
            l1_value_in = 64'h1000 + 64'(i);
            @(negedge clk_in);
        end
        l1_valid_in = 1'b0;
        check("full_ready_low", 256'(l1_ready_out), 256'(1'b0));
        l1_valid_in = 1'b1;
        l1_addr_in  = 22'h99;
        l1_value_in = 64'h9999;
        @(negedge clk_in);
        check("full_still_low", 256'(l1_ready_out), 256'(1'b0));
        check("full_head_hold", 256'({lc_valid_out, lc_we_out, lc_addr_out, lc_value_out}),
              256'({1'b1, 1'b1, 22'h10, 64'h1000}));
        l1_valid_in = 1'b0;
        lc_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_order_%0d", i),
                  256'({lc_valid_out, lc_we_out, lc_addr_out, lc_value_out}),
                  256'({1'b1, 1'b1, AW'(32'h10 + i), 64'h1000 + 64'(i)}));
            @(negedge clk_in);
        end
        check("drain_empty", 256'(lc_valid_out), 256'(1'b0));

        // Read held in RESP for five cycles with L1D back-pressure.
        apply(mk_in(0, 1, 0, 22'h55, 64'h0, 0, 1, 0, 64'h0));
        @(negedge clk_in);
        l1_valid_in = 1'b0;
        wait_rd_wait("hold_reach_rd_wait");
        lc_ready_in = 1'b0;
        lc_valid_in = 1'b1;
        lc_value_in = 64'h0123_4567_89AB_CDEF;
        @(negedge clk_in);
        lc_valid_in = 1'b0;
        lc_value_in = 64'h0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("resp_hold_%0d", i), 256'({l1_valid_out, l1_addr_out, l1_value_out}),
                  256'({1'b1, 22'h55, 64'h0123_4567_89AB_CDEF}));
            @(negedge clk_in);
        end
        l1_ready_in = 1'b1;
        check("resp_handshake", 256'({l1_valid_out, l1_addr_out, l1_value_out}),
              256'({1'b1, 22'h55, 64'h0123_4567_89AB_CDEF}));
        @(negedge clk_in);
        l1_ready_in = 1'b0;
        check("resp_done", 256'(l1_valid_out), 256'(1'b0));

        // Reset while waiting for lower-cache read data; late beat ignored.
        apply(mk_in(0, 1, 0, 22'h66, 64'h0, 0, 1, 0, 64'h0));
        @(negedge clk_in);
        l1_valid_in = 1'b0;
        wait_rd_wait("rst_reach_rd_wait");
        lc_ready_in = 1'b0;
        rst_in      = 1'b1;
        @(negedge clk_in);
        check("rst_all_zero", 256'(sample()), 256'(z));
        rst_in      = 1'b0;
        lc_valid_in = 1'b1;
        lc_value_in = 64'hDEAD;
        @(negedge clk_in);
        lc_valid_in = 1'b0;
        lc_value_in = 64'h0;
        check("rst_late_beat", 256'(sample()),
              256'(mk_out(1, 0, 0, 0, 22'h0, 64'h0, 0, 22'h0, 64'h0, 0)));

`ifdef WB_FWD_EN
        // Youngest-match forwarding with the lower cache stalled.
        apply(mk_in(0, 1, 1, 22'h30, 64'h1111, 0, 0, 0, 64'h0));
        @(negedge clk_in);
        l1_value_in = 64'h2222;
        @(negedge clk_in);
        l1_we_in    = 1'b0;
        l1_value_in = 64'h0;
        @(negedge clk_in);
        l1_valid_in = 1'b0;
        check("fwd_resp", 256'({l1_valid_out, l1_addr_out, l1_value_out}),
              256'({1'b1, 22'h30, 64'h2222}));
        check("fwd_no_lc_read", 256'(lc_valid_out), 256'(1'b0));
        l1_ready_in = 1'b1;
        @(negedge clk_in);
        l1_ready_in = 1'b0;
        lc_ready_in = 1'b1;
        check("fwd_drain_0", 256'({lc_valid_out, lc_we_out, lc_addr_out, lc_value_out}),
              256'({1'b1, 1'b1, 22'h30, 64'h1111}));
        @(negedge clk_in);
        check("fwd_drain_1", 256'({lc_valid_out, lc_we_out, lc_addr_out, lc_value_out}),
              256'({1'b1, 1'b1, 22'h30, 64'h2222}));
        @(negedge clk_in);
        check("fwd_drain_done", 256'(lc_valid_out), 256'(1'b0));

        // Forward from the head entry while it pops in the same cycle.
        apply(mk_in(0, 1, 1, 22'h31, 64'h3333, 0, 0, 0, 64'h0));
        @(negedge clk_in);
        apply(mk_in(0, 1, 0, 22'h31, 64'h0, 0, 1, 0, 64'h0));
        @(negedge clk_in);
        apply(mk_in(0, 0, 0, 22'h0, 64'h0, 0, 0, 0, 64'h0));
        check("fwd_head_pop", 256'({l1_valid_out, l1_addr_out, l1_value_out, lc_valid_out}),
              256'({1'b1, 22'h31, 64'h3333, 1'b0}));
        l1_ready_in = 1'b1;
        @(negedge clk_in);
        l1_ready_in = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/l1d_write_buffer.md
L1D_WRITE_BUFFER -- requirements
Module: l1d_write_buffer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset (clk_in, rst_in).
REQ-002 Parameter PADDR_BITS, 22, physical address width.
REQ-003 Parameter DEPTH, 4, write-buffer entries; power of two, minimum 2.
REQ-004 clk_in  input  1  clock; all state updates on rising edge.
REQ-005 rst_in  input  1  synchronous active-high reset.
REQ-006 l1_valid_in / l1_ready_out  input / output  1 / 1  request handshake from L1D miss/writeback port.
REQ-007 l1_addr_in  input  PADDR_BITS  request address.
REQ-008 l1_value_in  input  64  write data.
REQ-009 l1_we_in  input  1  1=write, 0=read.
REQ-010 l1_write_complete_out  output  1  one-cycle pulse acknowledging a posted write.
REQ-011 l1_valid_out / l1_ready_in  output / input  1 / 1  read-response handshake to L1D.
REQ-012 l1_addr_out / l1_value_out  output  PADDR_BITS / 64  read-response address and data.
REQ-013 lc_valid_out / lc_ready_in  output / input  1 / 1  request handshake to lower cache.
REQ-014 lc_addr_out / lc_value_out / lc_we_out  output  PADDR_BITS / 64 / 1  lower-cache request fields.
REQ-015 lc_valid_in / lc_ready_out  input / output  1 / 1  lower-cache read-data handshake.
REQ-016 lc_addr_in / lc_value_in  input  PADDR_BITS / 64  lower-cache read data; lc_addr_in is ignored.

Function
REQ-017 Write buffer SHALL be a FIFO of DEPTH {addr, data} entries with a count of width log2(DEPTH)+1; pointers SHALL wrap modulo DEPTH.
REQ-018 State machine SHALL have states IDLE, DRAIN, RD_REQ, RD_WAIT, RESP.
REQ-019 l1_ready_out SHALL be (state==IDLE) && (count<DEPTH); it SHALL not depend combinationally on l1_we_in.
REQ-020 An accepted write SHALL push its entry and pulse l1_write_complete_out in the following cycle.
REQ-021 In IDLE or DRAIN with count>0 and no read request pending on the LC port, the buffer SHALL drive lc_valid_out=1, lc_we_out=1 and the head entry; it SHALL pop on lc_ready_in.
REQ-022 A push and a pop in the same cycle SHALL leave count unchanged; a full buffer SHALL accept nothing until a pop.
REQ-023 An accepted read SHALL latch the address, then go to DRAIN if post-pop count>0, else to RD_REQ.
REQ-024 DRAIN SHALL go to RD_REQ in the cycle after count reaches 0.
REQ-025 RD_REQ SHALL drive lc_valid_out=1, lc_we_out=0 and the latched address; it SHALL go to RD_WAIT on lc_ready_in.
REQ-026 lc_ready_out SHALL be 1 only in RD_WAIT; an lc_valid_in beat there SHALL latch lc_value_in and go to RESP.
REQ-027 RESP SHALL hold l1_valid_out=1 with stable address and data until l1_ready_in, then return to IDLE.
REQ-028 At most one read SHALL be outstanding; writes SHALL never be reordered among themselves.

Reset
REQ-029 On rst_in the block SHALL enter IDLE, clear count and pointers, and discard all buffered writes and any outstanding read.
REQ-030 During and after reset, every valid, ready and pulse output SHALL be 0, and l1_addr_out, l1_value_out, lc_addr_out, lc_value_out and lc_we_out SHALL be 0; l1_ready_out SHALL rise in the first cycle after rst_in deasserts.
REQ-031 An lc_valid_in beat arriving after a mid-read reset SHALL be ignored.

Configuration
REQ-032 Macro WB_FWD_EN: when defined, a read whose address fully matches a buffered entry SHALL skip DRAIN and the LC, and go directly to RESP with the youngest match's data, so l1_valid_out is asserted the cycle after acceptance.
REQ-033 When WB_FWD_EN is defined, a match against the head entry popping in the same cycle SHALL still forward.
REQ-034 When WB_FWD_EN is undefined, every read SHALL follow REQ-023 through REQ-027 and no address comparators SHALL be built.

Verification
REQ-035 Write 0x0100/0xAAAA, lc_ready_in=1 -> l1_write_complete_out pulses once; one LC write to 0x0100 with data 0xAAAA.
REQ-036 lc_ready_in=0, four writes 0x10..0x13 -> l1_ready_out=0 after the fourth; raise lc_ready_in -> LC writes appear in order 0x10, 0x11, 0x12, 0x13.
REQ-037 Buffer holds 0x20; read 0x40 -> LC write to 0x20 precedes LC read to 0x40; lc_value_in=0xBEEF -> l1_value_out=0xBEEF.
REQ-038 WB_FWD_EN defined, lc_ready_in=0, writes 0x30/0x1111 then 0x30/0x2222, read 0x30 -> l1_valid_out next cycle with 0x2222 and no LC read.
REQ-039 rst_in asserted in RD_WAIT -> all outputs 0 next cycle; a later lc_valid_in is ignored and count=0.
REQ-040 l1_ready_in=0 in RESP for 5 cycles -> l1_valid_out, l1_addr_out and l1_value_out stay stable until the handshake.
